// File: rtl/phase_sequencer_if.sv
// Handshake bundle between the phase sequencer and its datapath.
// The master side drives the run/stop requests and done pulses; the sequencer is the slave.
interface phase_sequencer_if #(
    parameter int unsigned PHASE_WIDTH = 2,
    parameter int unsigned COUNT_WIDTH = 8
);
    logic                   enable;
    logic                   done;
    logic                   halt;
    logic                   start;
    logic [PHASE_WIDTH-1:0] phase;
    logic [COUNT_WIDTH-1:0] count;
    logic                   busy;
    logic                   halted;
    logic                   timeout;

    modport master (
        output enable, done, halt,
        input  start, phase, count, busy, halted, timeout
    );

    modport slave (
        input  enable, done, halt,
        output start, phase, count, busy, halted, timeout
    );
endinterface

// File: rtl/phase_sequencer.sv
// Multi-phase instruction sequencer: issues each phase, waits for done, counts instructions.
// Optional WAIT-phase watchdog enabled by defining PHASE_TIMEOUT_EN.
module phase_sequencer #(
    parameter int unsigned COUNT_WIDTH    = 8,
    parameter int unsigned NUM_PHASES     = 4,
    parameter int unsigned PHASE_WIDTH    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic               clk,
    input logic               reset,
    phase_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;

    localparam logic [PHASE_WIDTH-1:0] LAST_PHASE = PHASE_WIDTH'(NUM_PHASES - 1);

    if (NUM_PHASES < 2 || NUM_PHASES > 16 || PHASE_WIDTH < $clog2(NUM_PHASES) ||
        TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("phase_sequencer: illegal parameter combination");
    end

    state_t                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

`ifdef PHASE_TIMEOUT_EN
    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              timeout_q, timeout_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            count_q   <= '0;
`ifdef PHASE_TIMEOUT_EN
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            count_q   <= count_d;
`ifdef PHASE_TIMEOUT_EN
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        count_d   = count_q;
`ifdef PHASE_TIMEOUT_EN
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.halt)        state_d = HALT;
                else if (bus.enable) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef PHASE_TIMEOUT_EN
                wcnt_d  = '0;
`endif
            end
            WAIT: begin
                if (bus.done) begin
                    // enable/halt only matter once the final phase of an instruction completes
                    if (phase_q != LAST_PHASE) begin
                        phase_d = phase_q + 1'b1;
                        state_d = ISSUE;
                    end else begin
                        phase_d = '0;
                        count_d = count_q + 1'b1;
                        if (bus.halt)        state_d = HALT;
                        else if (bus.enable) state_d = ISSUE;
                        else                 state_d = IDLE;
                    end
                end
`ifdef PHASE_TIMEOUT_EN
                else if (wcnt_q == WCNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = HALT;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    assign bus.start  = (state_q == ISSUE);
    assign bus.busy   = (state_q == ISSUE) || (state_q == WAIT);
    assign bus.halted = (state_q == HALT);
    assign bus.phase  = phase_q;
    assign bus.count  = count_q;
`ifdef PHASE_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer (NUM_PHASES=4, COUNT_WIDTH=2).
module tb_phase_sequencer;
    logic clk;
    logic reset;
    int unsigned errors = 0;
    int unsigned checks = 0;

    phase_sequencer_if #(.PHASE_WIDTH(2), .COUNT_WIDTH(2)) bus ();

    phase_sequencer #(
        .COUNT_WIDTH(2),
        .NUM_PHASES(4),
        .PHASE_WIDTH(2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_start"},   32'(bus.start),   0);
        check({tag, "_phase"},   32'(bus.phase),   0);
        check({tag, "_count"},   32'(bus.count),   0);
        check({tag, "_busy"},    32'(bus.busy),    0);
        check({tag, "_halted"},  32'(bus.halted),  0);
        check({tag, "_timeout"}, 32'(bus.timeout), 0);
    endtask

    // Entered at the negedge where the sequencer sits in ISSUE for phase p.
    task automatic phase_step(input int unsigned p);
        check("issue_start", 32'(bus.start), 1);
        check("issue_phase", 32'(bus.phase), p);
        tick();
        check("wait_start", 32'(bus.start), 0);
        check("wait_busy",  32'(bus.busy),  1);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.done   = 1'b0;
        bus.halt   = 1'b0;
        tick();
        check_reset_vals("rst");
        reset = 1'b0;
        tick();
        check("idle_no_start", 32'(bus.start), 0);

        // Instruction 1: four phases back to back
        bus.enable = 1'b1;
        tick();
        for (int unsigned p = 0; p < 4; p++) phase_step(p);
        check("i1_count", 32'(bus.count), 1);
        check("i1_phase", 32'(bus.phase), 0);

        // Instruction 2: enable dropped during phase 1
        phase_step(0);
        bus.enable = 1'b0;
        for (int unsigned p = 1; p < 4; p++) phase_step(p);
        check("i2_count",  32'(bus.count), 2);
        check("i2_busy",   32'(bus.busy),  0);
        check("i2_start",  32'(bus.start), 0);
        check("i2_halted", 32'(bus.halted), 0);

        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("idle_done_ign_start", 32'(bus.start), 0);
        check("idle_done_ign_phase", 32'(bus.phase), 0);

        // Instructions 3 and 4: count 3 then wraps to 0
        bus.enable = 1'b1;
        tick();
        for (int unsigned p = 0; p < 4; p++) phase_step(p);
        check("i3_count", 32'(bus.count), 3);
        for (int unsigned p = 0; p < 4; p++) phase_step(p);
        check("i4_count_wrap", 32'(bus.count), 0);

        // Instruction 5: halt raised from phase 1, only honoured on the final phase
        phase_step(0);
        bus.halt = 1'b1;
        phase_step(1);
        check("halt_midinstr_start", 32'(bus.start), 1);
        check("halt_midinstr_phase", 32'(bus.phase), 2);
        phase_step(2);
        phase_step(3);
        check("halt_halted", 32'(bus.halted), 1);
        check("halt_busy",   32'(bus.busy),   0);
        check("halt_count",  32'(bus.count),  1);
        check("halt_phase",  32'(bus.phase),  0);
        bus.halt = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            check("halt_frozen_start",  32'(bus.start),  0);
            check("halt_frozen_count",  32'(bus.count),  1);
            check("halt_frozen_halted", 32'(bus.halted), 1);
            tick();
        end

        // Reset out of HALT, asynchronously
        bus.enable = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_vals("rst_halt");
        tick();
        reset = 1'b0;

        // Run to WAIT at phase 2, then reset between edges
        bus.enable = 1'b1;
        tick();
        phase_step(0);
        phase_step(1);
        check("pre_rst_phase", 32'(bus.phase), 2);
        tick();
        check("pre_rst_busy", 32'(bus.busy), 1);
        #2 reset = 1'b1;
        #1 check_reset_vals("rst_wait");
        tick();
        reset      = 1'b0;
        bus.enable = 1'b0;
        tick();
        check("post_rst_no_start", 32'(bus.start), 0);

        // Done withheld in WAIT
        bus.enable = 1'b1;
        tick();
        check("to_issue_start", 32'(bus.start), 1);
        bus.enable = 1'b0;
        tick();
`ifdef PHASE_TIMEOUT_EN
        repeat (15) tick();
        check("to_pre_busy",    32'(bus.busy),    1);
        check("to_pre_timeout", 32'(bus.timeout), 0);
        tick();
        check("to_timeout", 32'(bus.timeout), 1);
        check("to_halted",  32'(bus.halted),  1);
        check("to_busy",    32'(bus.busy),    0);
`else
        repeat (20) tick();
        check("nto_busy",    32'(bus.busy),    1);
        check("nto_timeout", 32'(bus.timeout), 0);
        check("nto_halted",  32'(bus.halted),  0);
        check("nto_phase",   32'(bus.phase),   0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter COUNT_WIDTH, default 8: width of the completed-instruction counter.
REQ-002 Parameter NUM_PHASES, default 4: phases per instruction (legal 2..16).
REQ-003 Parameter PHASE_WIDTH, default 2: width of phase; SHALL be >= ceil(log2(NUM_PHASES)).
REQ-004 Parameter TIMEOUT_CYCLES, default 16: WAIT cycles before timeout (used only when PHASE_TIMEOUT_EN is defined).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  run request, sampled at instruction boundaries.
REQ-008 done  input  1  current phase complete, one-cycle pulse from the datapath.
REQ-009 halt  input  1  stop request, sampled at instruction boundaries.
REQ-010 start  output  1  one-cycle pulse launching the phase on the phase port.
REQ-011 phase  output  PHASE_WIDTH  index of the phase in flight.
REQ-012 count  output  COUNT_WIDTH  number of completed instructions.
REQ-013 busy  output  1  high in ISSUE and WAIT.
REQ-014 halted  output  1  high in HALT.
REQ-015 timeout  output  1  sticky phase-timeout flag.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and HALT. All outputs SHALL be registered or decoded from registered state only.
REQ-017 IDLE: when enable=1 and halt=0, the FSM SHALL go to ISSUE; when halt=1, it SHALL go to HALT (halt has priority); otherwise it stays in IDLE.
REQ-018 ISSUE: start=1 for exactly this one cycle, then the FSM SHALL go to WAIT unconditionally.
REQ-019 WAIT, done=1, phase<NUM_PHASES-1: phase SHALL increment and the FSM SHALL go to ISSUE; enable and halt are ignored mid-instruction.
REQ-020 WAIT, done=1, phase=NUM_PHASES-1: phase SHALL return to 0 and count SHALL increment; the next state is HALT if halt=1, else ISSUE if enable=1, else IDLE.
REQ-021 count SHALL wrap modulo 2^COUNT_WIDTH without a flag.
REQ-022 done SHALL be ignored in IDLE, ISSUE and HALT.
REQ-023 Latency: enable sampled high in IDLE -> start high on the next cycle; done in WAIT -> next start on the next cycle (back-to-back phases are 2 cycles apart).
REQ-024 HALT SHALL be terminal until reset: start=0, and phase and count are frozen.
REQ-025 Simultaneous done and halt on a non-final phase: the phase SHALL advance and halt SHALL NOT be honoured.

Reset
REQ-026 Asserting reset SHALL immediately force IDLE, start=0, phase=0, count=0, busy=0, halted=0 and timeout=0, including mid-instruction.
REQ-027 After reset deasserts, the first start SHALL occur no earlier than one cycle after enable is sampled high.

Configuration
REQ-028 Macro PHASE_TIMEOUT_EN defined: a WAIT-cycle counter SHALL clear on entry to WAIT. If it reaches TIMEOUT_CYCLES with no done, timeout SHALL be set (sticky) and the FSM SHALL go to HALT.
REQ-029 Macro PHASE_TIMEOUT_EN undefined: the timeout port SHALL be tied to 0, there SHALL be no counter logic, and WAIT SHALL persist indefinitely.

Verification
REQ-030 Reset, then enable=1, NUM_PHASES=4, done pulsed 1 cycle after each start -> starts with phase 0,1,2,3, then count=1 and phase=0.
REQ-031 enable dropped during phase 1 -> phases 2 and 3 still issue, count=1, FSM in IDLE, busy=0.
REQ-032 halt=1 with done on phase 3 -> halted=1, count frozen at its incremented value, and further done/enable pulses produce no start.
REQ-033 COUNT_WIDTH=2, run 5 full instructions -> count sequence 1,2,3,0,1.
REQ-034 reset asserted in WAIT at phase 2 -> all outputs return to their reset values asynchronously, before the next clk edge.
REQ-035 PHASE_TIMEOUT_EN defined with TIMEOUT_CYCLES=16, done withheld -> timeout=1 and halted=1 after 16 WAIT cycles; PHASE_TIMEOUT_EN undefined -> timeout stays 0 and busy stays 1.
